// File: rtl/pwm_sched_pkg.sv
// Shared state encoding and default parameters for the LED breathing scheduler.
package pwm_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_HOLD = 3'd2,
    ST_DOWN = 3'd3,
    ST_NEXT = 3'd4
  } sched_state_e;

  localparam int DEF_TICK_DIV     = 5000;
  localparam int DEF_PWM_STEPS    = 100;
  localparam int DEF_DUTY_INC     = 5;
  localparam int DEF_STEP_PERIODS = 2;
  localparam int DEF_HOLD_PERIODS = 50;
  localparam int DEF_LED_NUM      = 4;

endpackage

// File: rtl/pwm_breath_scheduler_if.sv
// Control and LED-drive bundle between key/start logic and the breathing scheduler.
interface pwm_breath_scheduler_if
  import pwm_sched_pkg::*;
#(
  parameter int LED_NUM   = DEF_LED_NUM,
  parameter int PWM_STEPS = DEF_PWM_STEPS
);
  localparam int LW = $clog2(LED_NUM);
  localparam int DW = $clog2(PWM_STEPS + 1);

  logic               start;
  logic               stop;
  logic               mode;
  logic [LED_NUM-1:0] led_out;
  logic               busy;
  logic [LW-1:0]      cur_led;
  logic [DW-1:0]      duty;

  modport master (output start, stop, mode, input led_out, busy, cur_led, duty);
  modport slave  (input start, stop, mode, output led_out, busy, cur_led, duty);

endinterface

// File: rtl/pwm_tick_gen.sv
// Tick prescaler and PWM phase counter; both sit at zero while disabled.
module pwm_tick_gen
  import pwm_sched_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int PWM_STEPS = DEF_PWM_STEPS
) (
  input  logic                         sys_clk,
  input  logic                         sys_rst,
  input  logic                         en,
  output logic [$clog2(PWM_STEPS)-1:0] phase,
  output logic                         period_end
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = $clog2(PWM_STEPS);

  logic [TW-1:0] tick_cnt;
  logic          tick;

  assign tick       = en && (tick_cnt == TW'(TICK_DIV - 1));
  assign period_end = tick && (phase == PW'(PWM_STEPS - 1));

  always_ff @(posedge sys_clk) begin
    if (sys_rst || !en) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      phase    <= (phase == PW'(PWM_STEPS - 1)) ? '0 : phase + PW'(1);
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/pwm_breath_scheduler.sv
// Breathing sequencer: ramps a shared duty up/hold/down per PWM period and
// steers it to one LED (chase) or all LEDs (unison).
//
//   state   | meaning
//   IDLE    | outputs off, counters parked, waiting for start
//   UP      | duty rising by DUTY_INC every STEP_PERIODS periods
//   HOLD    | duty at full scale for HOLD_PERIODS periods
//   DOWN    | duty falling by DUTY_INC every STEP_PERIODS periods
//   NEXT    | one cycle: advance cur_led in chase mode, then UP
module pwm_breath_scheduler
  import pwm_sched_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int PWM_STEPS    = DEF_PWM_STEPS,
  parameter int DUTY_INC     = DEF_DUTY_INC,
  parameter int STEP_PERIODS = DEF_STEP_PERIODS,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS,
  parameter int LED_NUM      = DEF_LED_NUM
) (
  input logic                   sys_clk,
  input logic                   sys_rst,
  pwm_breath_scheduler_if.slave bus
);
  localparam int LW   = $clog2(LED_NUM);
  localparam int DW   = $clog2(PWM_STEPS + 1);
  localparam int PW   = $clog2(PWM_STEPS);
  localparam int SMAX = (STEP_PERIODS > HOLD_PERIODS) ? STEP_PERIODS : HOLD_PERIODS;
  localparam int SW   = (SMAX > 1) ? $clog2(SMAX) : 1;

  sched_state_e       state_q, state_n;
  logic [DW-1:0]      duty_q, duty_n;
  logic [LW-1:0]      cur_led_q, cur_led_n;
  logic               mode_q, mode_n;
  logic [SW-1:0]      step_q, step_n;
  logic [LED_NUM-1:0] led_q, led_n;
  logic [DW:0]        duty_ext;
  logic [PW-1:0]      phase;
  logic               period_end;
  logic               run_en;
  logic               pwm_on;

  // Stop parks the counters on the same edge that drops the FSM to IDLE.
  assign run_en = (state_q != ST_IDLE) && !bus.stop;

  pwm_tick_gen #(
    .TICK_DIV  (TICK_DIV),
    .PWM_STEPS (PWM_STEPS)
  ) u_tick_gen (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .en         (run_en),
    .phase      (phase),
    .period_end (period_end)
  );

  assign pwm_on = DW'(phase) < duty_q;

  always_comb begin
    state_n   = state_q;
    duty_n    = duty_q;
    cur_led_n = cur_led_q;
    mode_n    = mode_q;
    step_n    = step_q;
    duty_ext  = '0;
    led_n     = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n   = ST_UP;
          mode_n    = bus.mode;
          duty_n    = '0;
          cur_led_n = '0;
          step_n    = '0;
        end
      end
      ST_UP: begin
        if (period_end) begin
          if (step_q == SW'(STEP_PERIODS - 1)) begin
            step_n   = '0;
            duty_ext = {1'b0, duty_q} + (DW+1)'(DUTY_INC);
            if (duty_ext >= (DW+1)'(PWM_STEPS)) begin
              duty_n  = DW'(PWM_STEPS);
              state_n = ST_HOLD;
            end else begin
              duty_n = duty_ext[DW-1:0];
            end
          end else begin
            step_n = step_q + SW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (period_end) begin
          if (step_q == SW'(HOLD_PERIODS - 1)) begin
            step_n  = '0;
            state_n = ST_DOWN;
          end else begin
            step_n = step_q + SW'(1);
          end
        end
      end
      ST_DOWN: begin
        if (period_end) begin
          if (step_q == SW'(STEP_PERIODS - 1)) begin
            step_n   = '0;
            // the spare top bit flags a borrow below zero
            duty_ext = {1'b0, duty_q} - (DW+1)'(DUTY_INC);
            if (duty_ext[DW] || (duty_ext == '0)) begin
              duty_n  = '0;
              state_n = ST_NEXT;
            end else begin
              duty_n = duty_ext[DW-1:0];
            end
          end else begin
            step_n = step_q + SW'(1);
          end
        end
      end
      ST_NEXT: begin
        if (!mode_q) begin
          cur_led_n = (cur_led_q == LW'(LED_NUM - 1)) ? '0 : cur_led_q + LW'(1);
        end
        step_n  = '0;
        state_n = ST_UP;
      end
      default: state_n = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && bus.stop) begin
      state_n   = ST_IDLE;
      duty_n    = '0;
      cur_led_n = '0;
      step_n    = '0;
    end

    if (state_n != ST_IDLE) begin
      if (mode_q) led_n = {LED_NUM{pwm_on}};
      else        led_n[cur_led_q] = pwm_on;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= ST_IDLE;
      duty_q    <= '0;
      cur_led_q <= '0;
      mode_q    <= 1'b0;
      step_q    <= '0;
      led_q     <= '0;
    end else begin
      state_q   <= state_n;
      duty_q    <= duty_n;
      cur_led_q <= cur_led_n;
      mode_q    <= mode_n;
      step_q    <= step_n;
      led_q     <= led_n;
    end
  end

  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.duty    = duty_q;
  assign bus.cur_led = cur_led_q;
  assign bus.led_out = led_q;

endmodule

// File: doc/pwm_breath_scheduler.md
Name: pwm_breath_scheduler

Overview:
Sequencer for the LED PWM breathing datapath. It steps one shared PWM duty through a ramp-up, hold and ramp-down profile. It either chases the breathing pattern across LED_NUM LEDs one at a time (mode 0) or breathes all LEDs in unison (mode 1). Duty changes occur only at PWM period boundaries, so no partial-period glitches are visible on the LEDs. It sits between the board key/start logic and the LED pins.

Parameters:
TICK_DIV, 5000, sys_clk cycles per time tick (0.1 ms at 50 MHz).
PWM_STEPS, 100, ticks per PWM period; this is also the duty full scale (period is 10 ms).
DUTY_INC, 5, duty change per step; must divide PWM_STEPS.
STEP_PERIODS, 2, PWM periods between duty steps.
HOLD_PERIODS, 50, PWM periods held at full duty.
LED_NUM, 4, number of LED outputs (at least 2).

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a sequence
stop  in  1  one-cycle pulse; aborts to idle
mode  in  1  0 = chase, 1 = unison; sampled only on an accepted start
led_out  out  LED_NUM  LED drive, active-high
busy  out  1  high whenever state is not IDLE
cur_led  out  clog2(LED_NUM)  index of the active LED in chase mode
duty  out  clog2(PWM_STEPS+1)  current duty in ticks

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: state IDLE, all counters 0, led_out 0, busy 0, cur_led 0, duty 0, mode_r 0.
- Tick counter: counts 0..TICK_DIV-1 and is held at 0 in IDLE. The tick pulse fires when the count equals TICK_DIV-1.
- Phase counter: counts 0..PWM_STEPS-1 and advances on each tick; held at 0 in IDLE.
- period_end: tick AND phase == PWM_STEPS-1.
- PWM compare: pwm_on = (phase < duty). duty 0 gives always off; duty PWM_STEPS gives always on.
- led_out is registered one cycle after the compare.
  - Chase: only bit cur_led is driven by pwm_on; all other bits are 0.
  - Unison: all bits equal pwm_on.
- Step counter: counts period_end events, 0..STEP_PERIODS-1 in UP/DOWN and 0..HOLD_PERIODS-1 in HOLD. It clears on every state change.
- FSM states and transitions:
  - IDLE: on start (and no stop) latch mode_r, set duty 0 and cur_led 0, go to UP.
  - UP: on period_end with step count == STEP_PERIODS-1, duty += DUTY_INC, saturating at PWM_STEPS. The update that reaches PWM_STEPS also moves the FSM to HOLD.
  - HOLD: duty stays PWM_STEPS. On the HOLD_PERIODS-th period_end, go to DOWN.
  - DOWN: stepped like UP, with duty -= DUTY_INC saturating at 0. The update that reaches 0 moves the FSM to NEXT.
  - NEXT: one cycle. In chase mode, cur_led increments and wraps LED_NUM-1 -> 0. In unison mode, cur_led is unchanged. Then go to UP. Counters are not cleared, so the PWM period stays continuous.
- The sequence repeats indefinitely until stop.
- stop in any non-IDLE state: next cycle state IDLE, duty 0, led_out 0, cur_led 0, counters 0, busy 0.
- start while busy is ignored. start and stop in the same cycle: stop wins; from IDLE, the block stays IDLE.
- mode changes while busy have no effect until the next accepted start.
- Reset asserted mid-sequence: all reset values are restored on the next edge, regardless of other inputs.
- Widths: duty arithmetic uses one extra bit internally so saturation is computed without wrap.

Decomposition:
- Package pwm_sched_pkg: FSM state encodings (IDLE, UP, HOLD, DOWN, NEXT) and default parameter constants.
- Sub-module pwm_tick_gen: tick counter, phase counter and period_end. Its inputs are sys_clk, sys_rst and an enable (busy); its outputs are phase and period_end.
- FSM, duty register and output mux remain in the top level.

Test Plan:
All tests use TICK_DIV=2, PWM_STEPS=10, DUTY_INC=5, STEP_PERIODS=1, HOLD_PERIODS=2, LED_NUM=4 (PWM period = 20 clocks).
- Reset/idle: assert sys_rst for 3 cycles, no start -> led_out=0, busy=0, duty=0, cur_led=0 held for 200 cycles.
- Ramp profile: start with mode=0 -> duty sequence 0,5,10 (HOLD for 2 periods),5,0, with each change exactly at period_end. During duty=5, led_out[0] is high for 10 clocks of each 20-clock period; led_out[3:1] stay 0.
- Chase wrap: run 4 full profiles -> cur_led goes 0,1,2,3,0. Only the addressed led_out bit ever toggles.
- Unison: start with mode=1 -> all 4 bits of led_out are identical every cycle and cur_led stays 0.
- Stop/start collisions: stop mid-HOLD -> next cycle busy=0, led_out=0, duty=0. start+stop in the same cycle from IDLE -> remains IDLE. start while busy -> no change to state or duty.
- Reset mid-sequence: assert sys_rst during DOWN with duty=5 -> after one edge, all outputs are at reset values and stay idle until the next start.
